// File: rtl/imem_responder.sv
// Instruction-memory responder: valid/ready fetch port, programmable wait states, registered response, load port.
// Optional: define IMEM_FAULT_NOP_EN to return a NOP (32'h0000_0013) instead of zero on faulting fetches.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [31:0]   req_addr_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_data_o,
    output logic          rsp_err_o,
    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [31:0]   ld_data_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
`ifdef IMEM_FAULT_NOP_EN
    localparam logic [31:0] FAULT_WORD = 32'h0000_0013;
`else
    localparam logic [31:0] FAULT_WORD = 32'h0000_0000;
`endif

    function automatic logic is_fault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < BASE_ADDR) ||
               ({1'b0, (addr - BASE_ADDR)} >= SPAN_BYTES);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
        return AW'((addr - BASE_ADDR) >> 2);
    endfunction

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;
    logic          req_ready_s;
    logic          accept_s;
    logic          load_rsp_s;
    logic [31:0]   rd_addr_s;
    logic [31:0]   mem_q [DEPTH_WORDS];

    // Next-state, handshake and response-capture logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        err_d       = err_q;
        req_ready_s = 1'b0;
        accept_s    = 1'b0;
        load_rsp_s  = 1'b0;
        rd_addr_s   = addr_q;

        case (state_q)
            S_IDLE:  req_ready_s = 1'b1;
            S_WAIT:  req_ready_s = 1'b0;
            S_RESP:  req_ready_s = rsp_ready_i;
            default: req_ready_s = 1'b0;
        endcase
        accept_s = req_valid_i & req_ready_s;

        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept_s) begin
                    addr_d = req_addr_i;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        // Zero wait states: the fresh address goes straight to the read port.
                        state_d    = S_RESP;
                        load_rsp_s = 1'b1;
                        rd_addr_s  = req_addr_i;
                    end
                end else if ((state_q == S_RESP) && rsp_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    load_rsp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_rsp_s) begin
            err_d  = is_fault(rd_addr_s);
            data_d = err_d ? FAULT_WORD : mem_q[word_idx(rd_addr_s)];
        end else begin
            err_d  = err_q;
            data_d = data_q;
        end
    end

    // FSM, wait counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0000_0000;
            data_q  <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Load port; the array is deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (ld_we_i) begin
            mem_q[ld_addr_i] <= ld_data_i;
        end
    end

    assign req_ready_o = req_ready_s;
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_data_o  = data_q;
    assign rsp_err_o   = err_q;

`ifndef SYNTHESIS
    imem_responder_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_i (req_ready_s),
        .req_addr_i  (req_addr_i),
        .rsp_valid_i (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_i  (data_q)
    );
`endif

endmodule

// Protocol checker for the fetch handshake (simulation only).
module imem_responder_chk (
    input logic        clk,
    input logic        rst,
    input logic        req_valid_i,
    input logic        req_ready_i,
    input logic [31:0] req_addr_i,
    input logic        rsp_valid_i,
    input logic        rsp_ready_i,
    input logic [31:0] rsp_data_i
);

    a_req_addr_stable: assert property (@(posedge clk) disable iff (rst)
        (req_valid_i && !req_ready_i) |=> $stable(req_addr_i));

    a_rsp_data_stable: assert property (@(posedge clk) disable iff (rst)
        (rsp_valid_i && !rsp_ready_i) |=> $stable(rsp_data_i));

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: three instances (1, 0 and 3 wait states) share one clock.
module tb_imem_responder;

    localparam int N = 3;

`ifdef IMEM_FAULT_NOP_EN
    localparam logic [31:0] FAULT_WORD = 32'h0000_0013;
`else
    localparam logic [31:0] FAULT_WORD = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst_s       [N];
    logic        req_valid_s [N];
    logic        req_ready_s [N];
    logic [31:0] req_addr_s  [N];
    logic        rsp_valid_s [N];
    logic        rsp_ready_s [N];
    logic [31:0] rsp_data_s  [N];
    logic        rsp_err_s   [N];
    logic        ld_we_s     [N];
    logic [7:0]  ld_addr_s   [N];
    logic [31:0] ld_data_s   [N];

    logic [31:0] model_mem [N][256];
    logic [32:0] exp_q [$];
    int          checks_n = 0;
    int          errors_n = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        imem_responder #(
            .DEPTH_WORDS (256),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
            .BASE_ADDR   (32'h0000_0000)
        ) u_dut (
            .clk         (clk),
            .rst         (rst_s[g]),
            .req_valid_i (req_valid_s[g]),
            .req_ready_o (req_ready_s[g]),
            .req_addr_i  (req_addr_s[g]),
            .rsp_valid_o (rsp_valid_s[g]),
            .rsp_ready_i (rsp_ready_s[g]),
            .rsp_data_o  (rsp_data_s[g]),
            .rsp_err_o   (rsp_err_s[g]),
            .ld_we_i     (ld_we_s[g]),
            .ld_addr_i   (ld_addr_s[g]),
            .ld_data_i   (ld_data_s[g])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    function automatic logic [32:0] expect_rsp(input int k, input logic [31:0] addr);
        if ((addr[1:0] != 2'b00) || (addr >= 32'h0000_0400)) begin
            return {1'b1, FAULT_WORD};
        end
        return {1'b0, model_mem[k][addr[9:2]]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_n++;
        if (obs !== exp) begin
            errors_n++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input int idx, input logic [31:0] d);
        ld_we_s[k]   = 1'b1;
        ld_addr_s[k] = 8'(idx);
        ld_data_s[k] = d;
        tick();
        ld_we_s[k]   = 1'b0;
        model_mem[k][idx] = d;
    endtask

    // Issue one fetch, wait for accept, then measure cycles to rsp_valid.
    task automatic fetch(input int k, input logic [31:0] addr);
        int  n;
        bit  seen;
        tick();
        req_valid_s[k] = 1'b1;
        req_addr_s[k]  = addr;
        exp_q.push_back(expect_rsp(k, addr));
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = req_ready_s[k];
        end
        check_eq("accept", 32'(seen), 32'd1);
        tick();
        req_valid_s[k] = 1'b0;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = rsp_valid_s[k];
        end
        check_eq("latency", 32'(n), 32'(ws_of(k) + 1));
    endtask

    // Scoreboard: every consumed response is compared with the oldest expectation.
    always @(negedge clk) begin : mon
        logic [32:0] e_v;
        for (int k = 0; k < N; k++) begin
            if (!rst_s[k] && rsp_valid_s[k] && rsp_ready_s[k]) begin
                if (exp_q.size() == 0) begin
                    check_eq("rsp_extra", 32'd1, 32'd0);
                end else begin
                    e_v = exp_q.pop_front();
                    check_eq("rsp_data", rsp_data_s[k], e_v[31:0]);
                    check_eq("rsp_err", 32'(rsp_err_s[k]), 32'(e_v[32]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            rst_s[k]       = 1'b1;
            req_valid_s[k] = 1'b0;
            req_addr_s[k]  = 32'h0000_0000;
            rsp_ready_s[k] = 1'b1;
            ld_we_s[k]     = 1'b0;
            ld_addr_s[k]   = 8'd0;
            ld_data_s[k]   = 32'h0000_0000;
        end
        #2;
        for (int k = 0; k < N; k++) begin
            check_eq("rst_req_ready", 32'(req_ready_s[k]), 32'd1);
            check_eq("rst_rsp_valid", 32'(rsp_valid_s[k]), 32'd0);
            check_eq("rst_rsp_data", rsp_data_s[k], 32'h0000_0000);
            check_eq("rst_rsp_err", 32'(rsp_err_s[k]), 32'd0);
        end
        tick();
        tick();
        for (int k = 0; k < N; k++) rst_s[k] = 1'b0;

        // Basic fetches and faults, one wait state
        load(0, 0, 32'h0000_0013);
        load(0, 1, 32'h0340_0093);
        fetch(0, 32'h0000_0000);
        fetch(0, 32'h0000_0004);
        fetch(0, 32'h0000_0002);
        fetch(0, 32'h0000_0400);

        // Backpressure: response held five cycles
        tick();
        rsp_ready_s[0] = 1'b0;
        fetch(0, 32'h0000_0004);
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(rsp_valid_s[0]), 32'd1);
            check_eq("bp_data", rsp_data_s[0], 32'h0340_0093);
            check_eq("bp_err", 32'(rsp_err_s[0]), 32'd0);
            check_eq("bp_req_ready", 32'(req_ready_s[0]), 32'd0);
        end
        tick();
        rsp_ready_s[0] = 1'b1;
        #1;
        check_eq("bp_req_ready_comb", 32'(req_ready_s[0]), 32'd1);
        @(negedge clk);
        check_eq("bp_last_valid", 32'(rsp_valid_s[0]), 32'd1);
        @(negedge clk);
        check_eq("bp_idle", 32'(rsp_valid_s[0]), 32'd0);

        // Same-edge write and response read of word 1
        tick();
        req_valid_s[0] = 1'b1;
        req_addr_s[0]  = 32'h0000_0004;
        exp_q.push_back(expect_rsp(0, 32'h0000_0004));
        tick();
        req_valid_s[0] = 1'b0;
        ld_we_s[0]     = 1'b1;
        ld_addr_s[0]   = 8'd1;
        ld_data_s[0]   = 32'hDEAD_BEEF;
        tick();
        ld_we_s[0] = 1'b0;
        model_mem[0][1] = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("hz_valid", 32'(rsp_valid_s[0]), 32'd1);
        check_eq("hz_old", rsp_data_s[0], 32'h0340_0093);
        fetch(0, 32'h0000_0004);

        // Zero wait states, back-to-back streaming
        for (int i = 0; i < 4; i++) load(1, i, 32'hA5A5_0000 | 32'(i));
        tick();
        req_valid_s[1] = 1'b1;
        req_addr_s[1]  = 32'h0000_0000;
        exp_q.push_back(expect_rsp(1, 32'h0000_0000));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("bb_req_ready", 32'(req_ready_s[1]), 32'd1);
            if (i > 0) check_eq("bb_valid", 32'(rsp_valid_s[1]), 32'd1);
            tick();
            if (i < 3) begin
                req_addr_s[1] = 32'((i + 1) * 4);
                exp_q.push_back(expect_rsp(1, 32'((i + 1) * 4)));
            end else begin
                req_valid_s[1] = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("bb_last_valid", 32'(rsp_valid_s[1]), 32'd1);
        @(negedge clk);
        check_eq("bb_idle", 32'(rsp_valid_s[1]), 32'd0);

        // Reset in the middle of a three-wait-state fetch
        load(2, 5, 32'hCAFE_F00D);
        req_valid_s[2] = 1'b1;
        req_addr_s[2]  = 32'h0000_0014;
        tick();
        req_valid_s[2] = 1'b0;
        tick();
        rst_s[2] = 1'b1;
        #1;
        check_eq("mr_req_ready", 32'(req_ready_s[2]), 32'd1);
        check_eq("mr_rsp_valid", 32'(rsp_valid_s[2]), 32'd0);
        load(2, 6, 32'h1234_5678);
        @(negedge clk);
        check_eq("mr_hold_valid", 32'(rsp_valid_s[2]), 32'd0);
        tick();
        rst_s[2] = 1'b0;
        fetch(2, 32'h0000_0014);
        fetch(2, 32'h0000_0018);

        tick();
        tick();
        check_eq("q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

endmodule
